// File: rtl/gravity_timer_if.sv
// Game-side bundle for gravity_timer: control levels, drop handshake, status and clock digits.
interface gravity_timer_if;
  logic       start;
  logic       pause;
  logic       game_over;
  logic [3:0] level;
  logic       soft_drop;
  logic       drop_ack;
  logic       drop_req;
  logic       overrun;
  logic [1:0] state;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       sec_wrap;

  modport master (
    output start, pause, game_over, level, soft_drop, drop_ack,
    input  drop_req, overrun, state, sec_tens, sec_ones, sec_wrap
  );

  modport slave (
    input  start, pause, game_over, level, soft_drop, drop_ack,
    output drop_req, overrun, state, sec_tens, sec_ones, sec_wrap
  );
endinterface

// File: rtl/gravity_timer.sv
// Level-scaled drop timer with drop_req/ack handshake and a BCD elapsed-seconds clock.
// Soft-drop acceleration is compiled in only when GRAVITY_SOFTDROP_EN is defined.
//
// state  | meaning
// IDLE   | no game yet; counters held at zero
// RUN    | gravity and seconds advance
// PAUSED | everything frozen; a pending drop can still be acknowledged
// OVER   | game finished; values held until start
module gravity_timer #(
  parameter int BASE_PERIOD = 25_000_000,
  parameter int STEP_PERIOD = 2_400_000,
  parameter int SOFT_PERIOD = 1_250_000,
  parameter int ONE_SEC     = 50_000_000
) (
  input logic            clk,
  input logic            rst,
  gravity_timer_if.slave bus
);
  localparam int CNT_W = $clog2(BASE_PERIOD + 1);
  localparam int PRE_W = (ONE_SEC > 1) ? $clog2(ONE_SEC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_OVER   = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_run;
  logic               w_clear;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [PRE_W-1:0]   r_presc;
  logic [2:0]         r_sec_tens;
  logic [3:0]         r_sec_ones;
  logic               r_sec_wrap;
  logic               r_drop_req;
  logic               r_overrun;
  logic [3:0]         w_lvl;
  logic [31:0]        w_period_full;
  logic [31:0]        w_eff_full;
  logic [CNT_W-1:0]   w_period_m1;
  logic               w_expire;
  logic               w_sec_tick;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Priority: game_over, then start, then pause.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = (r_state == S_RUN);
    w_clear     = 1'b0;
    if (bus.game_over) begin
      w_state_nxt = S_OVER;
    end else if (bus.start && (r_state == S_IDLE || r_state == S_OVER)) begin
      w_state_nxt = S_RUN;
      w_clear     = 1'b1;
    end else if (r_state == S_RUN && bus.pause) begin
      w_state_nxt = S_PAUSED;
    end else if (r_state == S_PAUSED && !bus.pause) begin
      w_state_nxt = S_RUN;
    end
  end

  assign w_lvl         = (bus.level > 4'd9) ? 4'd9 : bus.level;
  assign w_period_full = 32'(BASE_PERIOD) - (32'(w_lvl) * 32'(STEP_PERIOD));
`ifdef GRAVITY_SOFTDROP_EN
  assign w_eff_full = (bus.soft_drop && (32'(SOFT_PERIOD) < w_period_full)) ?
                      32'(SOFT_PERIOD) : w_period_full;
`else
  assign w_eff_full = w_period_full;
`endif
  assign w_period_m1 = w_eff_full[CNT_W-1:0] - CNT_W'(1);
  // >= rather than == so a period shortened below the current count still fires.
  assign w_expire    = w_run && (r_drop_cnt >= w_period_m1);
  assign w_sec_tick  = w_run && (r_presc == PRE_W'(ONE_SEC - 1));

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_drop_cnt <= '0;
      r_presc    <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
      r_sec_wrap <= 1'b0;
      r_drop_req <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sec_wrap <= 1'b0;
      if (w_run) begin
        r_drop_cnt <= w_expire ? '0 : r_drop_cnt + CNT_W'(1);
        r_presc    <= w_sec_tick ? '0 : r_presc + PRE_W'(1);
      end
      if (w_sec_tick) begin
        if (r_sec_ones == 4'd9) begin
          r_sec_ones <= 4'd0;
          if (r_sec_tens == 3'd5) begin
            r_sec_tens <= 3'd0;
            r_sec_wrap <= 1'b1;
          end else begin
            r_sec_tens <= r_sec_tens + 3'd1;
          end
        end else begin
          r_sec_ones <= r_sec_ones + 4'd1;
        end
      end
      // A fresh expiry wins over a same-cycle ack; only an unacked one overruns.
      if (w_expire) begin
        r_drop_req <= 1'b1;
        if (r_drop_req && !bus.drop_ack) r_overrun <= 1'b1;
      end else if (r_drop_req && bus.drop_ack) begin
        r_drop_req <= 1'b0;
      end
    end
  end

  assign bus.drop_req = r_drop_req;
  assign bus.overrun  = r_overrun;
  assign bus.state    = r_state;
  assign bus.sec_tens = r_sec_tens;
  assign bus.sec_ones = r_sec_ones;
  assign bus.sec_wrap = r_sec_wrap;
endmodule
